data_loader_8: RTL and testbench
================================

Name: data_loader_8

Overview:
- Accepts 32-bit APF bridge write words and replays them as a serial stream of byte writes for a byte-wide memory.
- Sits between the bridge write bus and a byte-addressed RAM or BRAM loader port.
- Runs in a single clock domain.
- Words are queued in an internal FIFO and drained one byte per fixed-length slot.

Parameters:
- ADDRESS_SIZE, 15: width of write_addr; taken from bridge_addr[ADDRESS_SIZE-1:0].
- ADDRESS_MASK_UPPER_4, 4'h0: a bridge write is accepted only when bridge_addr[31:28] equals this value.
- WRITE_MEM_CLOCK_DELAY, 4: length of one byte slot in clocks; minimum 2.
- WRITE_MEM_EN_CYCLE_LENGTH, 1: clocks that write_en stays high at the start of each slot; must be less than WRITE_MEM_CLOCK_DELAY.
- FIFO_DEPTH, 16: number of words in the FIFO; power of two.

Ports:
- clk_74a  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- bridge_wr  in  1  bridge write strobe; each clock it is high is one word.
- bridge_endian_little  in  1  byte order of the word being written; sampled together with it.
- bridge_addr  in  32  byte address of the word.
- bridge_wr_data  in  32  word data.
- write_en  out  1  memory write strobe.
- write_addr  out  ADDRESS_SIZE  byte address for the memory write.
- write_data  out  8  byte data for the memory write.

Behaviour:
- Reset state: write_en=0, write_addr=0, write_data=0; FIFO empty; slot counter idle. Reset asserted mid-operation discards all queued and in-flight bytes immediately.
- Accept rule: on a rising edge with bridge_wr=1 and bridge_addr[31:28]==ADDRESS_MASK_UPPER_4, push {endian, bridge_addr[ADDRESS_SIZE-1:2], data} into the FIFO. Non-matching writes are ignored.
- Full FIFO: an accepted write is dropped and the FIFO contents are left unchanged.
- Push and pop may happen in the same cycle.
- Unpack: when idle and the FIFO is non-empty, pop one word and emit 4 byte slots.
- Byte order, endian=0: byte 0 = data[31:24], byte 1 = [23:16], byte 2 = [15:8], byte 3 = [7:0].
- Byte order, endian=1: the order is reversed ([7:0] first).
- Byte k is written at address {addr_word, k[1:0]}; bridge_addr[1:0] is ignored.
- Slot timing: write_en is high for the first WRITE_MEM_EN_CYCLE_LENGTH clocks of each slot, then low for the rest of it. write_addr and write_data are valid from the first clock of the slot and held stable until the next slot begins.
- After the last slot, write_addr and write_data hold their values.
- Latency: for a word accepted at edge T0 into an empty, idle block, write_en is high in the cycle after edge T0+3 (3 clocks after capture).
- Later bytes follow every WRITE_MEM_CLOCK_DELAY clocks.
- Back-to-back: if the FIFO is non-empty when byte 3's slot ends, the next word's byte 0 slot starts on the very next clock, with no idle gap.
- Throughput: one word every 4*WRITE_MEM_CLOCK_DELAY clocks. Bursts up to FIFO_DEPTH words plus the one in flight are absorbed.

Optional Feature:
- Macro: DATA_LOADER_OVERFLOW_FLAG_EN.
- When defined, add an output port overflow (1 bit). It goes high one clock after an accepted write is dropped because the FIFO is full. It is sticky until reset.
- When undefined, the port does not exist and drops are silent.

Test Plan:
- Reset held for 10 clocks, no bridge activity -> write_en=0, write_addr=0, write_data=0 throughout.
- One word, endian=0, addr=0x0000000C, data=0xAABBCCDD -> four 1-clock write_en pulses 4 clocks apart: (0xC,0xAA), (0xD,0xBB), (0xE,0xCC), (0xF,0xDD). First pulse 3 clocks after capture; write_en low for the 3 clocks after each pulse.
- Second word addr=0x20, data=0xFFEEDDCC after idle -> (0x20,0xFF), (0x21,0xEE), (0x22,0xDD), (0x23,0xCC) with the same timing.
- Endian=1, addr=0x40, data=0x11223344 -> (0x40,0x44), (0x41,0x33), (0x42,0x22), (0x43,0x11).
- Burst of 17 consecutive writes (addr 0x100 + 4n, data n) -> 68 gapless slots with addresses 0x100..0x143. Filter: a write with addr[31:28]=4'h1 emits nothing.
- Overflow: with the FIFO full, 2 more writes -> both dropped; overflow=1 when the macro is defined. Reset asserted mid-burst -> outputs are 0 on the next clock and no further pulses occur.

Source files
------------

// File: rtl/data_loader_8.sv
// Bridge word to byte-stream loader: FIFO-buffered 32-bit writes replayed as timed byte writes.
// Optional macro DATA_LOADER_OVERFLOW_FLAG_EN adds a sticky overflow output.
module data_loader_8 #(
    parameter int         ADDRESS_SIZE              = 15,
    parameter logic [3:0] ADDRESS_MASK_UPPER_4      = 4'h0,
    parameter int         WRITE_MEM_CLOCK_DELAY     = 4,
    parameter int         WRITE_MEM_EN_CYCLE_LENGTH = 1,
    parameter int         FIFO_DEPTH                = 16
) (
    input  logic                    clk_74a,
    input  logic                    reset,
    input  logic                    bridge_wr,
    input  logic                    bridge_endian_little,
    input  logic [31:0]             bridge_addr,
    input  logic [31:0]             bridge_wr_data,
    output logic                    write_en,
    output logic [ADDRESS_SIZE-1:0] write_addr,
    output logic [7:0]              write_data
`ifdef DATA_LOADER_OVERFLOW_FLAG_EN
    ,
    output logic                    overflow
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WA = ADDRESS_SIZE - 2;
    localparam int EW = 1 + WA + 32;
    localparam int CW = $clog2(WRITE_MEM_CLOCK_DELAY);

    localparam logic [CW-1:0] CNT_LAST = CW'(WRITE_MEM_CLOCK_DELAY - 1);
    localparam logic [CW-1:0] CNT_EN   = CW'(WRITE_MEM_EN_CYCLE_LENGTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          empty;
    logic          full;
    logic          hit;
    logic          push;
    logic          pop;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [EW-1:0] cur;
    logic          slot_end;
    logic          last_byte;
    logic [1:0]    sel;
    logic [7:0]    cur_byte;

    logic unused_addr;
    assign unused_addr = ^{bridge_addr[27:ADDRESS_SIZE], bridge_addr[1:0]};

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign hit   = bridge_wr && (bridge_addr[31:28] == ADDRESS_MASK_UPPER_4);
    assign push  = hit && !full;

    assign slot_end  = (state == S_RUN) && (cnt == CNT_LAST);
    assign last_byte = (idx == 2'd3);
    // Prefetch on the last clock of byte 3 so the next word runs gapless
    assign pop = !empty &&
                 ((state == S_IDLE) || (slot_end && last_byte));

    always_ff @(posedge clk_74a) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {bridge_endian_little,
                                    bridge_addr[ADDRESS_SIZE-1:2],
                                    bridge_wr_data};
        end
    end

    always_ff @(posedge clk_74a or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Little-endian words are drained low byte first
    assign sel = cur[EW-1] ? ~idx : idx;

    always_comb begin
        cur_byte = 8'h00;
        unique case (sel)
            2'd0: cur_byte = cur[31:24];
            2'd1: cur_byte = cur[23:16];
            2'd2: cur_byte = cur[15:8];
            2'd3: cur_byte = cur[7:0];
            default: cur_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk_74a or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idx        <= 2'd0;
            cur        <= '0;
            write_en   <= 1'b0;
            write_addr <= '0;
            write_data <= 8'h00;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (pop) begin
                        cur   <= mem[rd_ptr[AW-1:0]];
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    cnt   <= '0;
                    idx   <= 2'd0;
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (cnt == '0) begin
                        write_en   <= 1'b1;
                        write_addr <= {cur[32 +: WA], idx};
                        write_data <= cur_byte;
                    end else if (cnt == CNT_EN) begin
                        write_en <= 1'b0;
                    end
                    if (slot_end) begin
                        cnt <= '0;
                        if (last_byte) begin
                            if (pop) begin
                                cur <= mem[rd_ptr[AW-1:0]];
                                idx <= 2'd0;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DATA_LOADER_OVERFLOW_FLAG_EN
    always_ff @(posedge clk_74a or posedge reset) begin
        if (reset)
            overflow <= 1'b0;
        else if (hit && full)
            overflow <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_data_loader_8.sv
// Scoreboard bench for data_loader_8: expected byte writes and their clock
// are queued at drive time and compared on each write_en pulse.
module tb_data_loader_8;

    logic        clk_74a = 1'b0;
    logic        reset = 1'b1;
    logic        bridge_wr = 1'b0;
    logic        bridge_endian_little = 1'b0;
    logic [31:0] bridge_addr = '0;
    logic [31:0] bridge_wr_data = '0;
    logic        write_en;
    logic [14:0] write_addr;
    logic [7:0]  write_data;
`ifdef DATA_LOADER_OVERFLOW_FLAG_EN
    logic        overflow;
`endif

    data_loader_8 dut (
        .clk_74a              (clk_74a),
        .reset                (reset),
        .bridge_wr            (bridge_wr),
        .bridge_endian_little (bridge_endian_little),
        .bridge_addr          (bridge_addr),
        .bridge_wr_data       (bridge_wr_data),
        .write_en             (write_en),
        .write_addr           (write_addr),
        .write_data           (write_data)
`ifdef DATA_LOADER_OVERFLOW_FLAG_EN
        ,
        .overflow             (overflow)
`endif
    );

    always #5 clk_74a = ~clk_74a;

    typedef struct {
        logic [14:0] a;
        logic [7:0]  d;
        longint      t;
    } exp_t;

    exp_t   sb[$];
    int     n_cmp = 0;
    int     n_err = 0;
    longint cyc = 0;
    longint last_start = -1000;
    logic   prev_en = 1'b0;

    always @(posedge clk_74a) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, act, exp, cyc);
        end
    endtask

    // Pulse monitor: each rising write_en consumes one scoreboard entry
    always @(negedge clk_74a) begin
        exp_t e;
        if (write_en === 1'b1) begin
            check("en_width", {63'd0, prev_en}, 64'd0);
            if (!prev_en) begin
                if (sb.size() == 0) begin
                    check("spurious_en", {63'd0, write_en}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("addr", {49'd0, write_addr}, {49'd0, e.a});
                    check("data", {56'd0, write_data}, {56'd0, e.d});
                    check("time", cyc, e.t);
                end
            end
        end
        prev_en = write_en;
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic e, input bit acc);
        longint cap;
        longint st;
        logic [7:0] b;
        @(negedge clk_74a);
        bridge_wr            = 1'b1;
        bridge_addr          = a;
        bridge_wr_data       = d;
        bridge_endian_little = e;
        cap = cyc + 1;
        if (acc) begin
            st = (cap + 3 > last_start + 16) ? cap + 3 : last_start + 16;
            last_start = st;
            for (int k = 0; k < 4; k++) begin
                b = e ? 8'(d >> (8 * k)) : 8'(d >> (8 * (3 - k)));
                sb.push_back('{{a[14:2], 2'(k)}, b, st + 4 * k});
            end
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk_74a);
        bridge_wr = 1'b0;
        repeat (n - 1) @(negedge clk_74a);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 400) begin
            @(negedge clk_74a);
            t++;
        end
        check("drain", 64'(sb.size()), 64'd0);
        repeat (8) @(negedge clk_74a);
    endtask

    initial begin
        repeat (10) begin
            @(negedge clk_74a);
            check("rst_en", {63'd0, write_en}, 64'd0);
            check("rst_addr", {49'd0, write_addr}, 64'd0);
            check("rst_data", {56'd0, write_data}, 64'd0);
`ifdef DATA_LOADER_OVERFLOW_FLAG_EN
            check("rst_ovf", {63'd0, overflow}, 64'd0);
`endif
        end
        reset = 1'b0;

        wr(32'h0000_000C, 32'hAABB_CCDD, 1'b0, 1'b1);
        idle(1);
        drain();
        check("hold_addr", {49'd0, write_addr}, 64'h0F);
        check("hold_data", {56'd0, write_data}, 64'hDD);

        wr(32'h0000_0020, 32'hFFEE_DDCC, 1'b0, 1'b1);
        idle(1);
        drain();

        wr(32'h0000_0040, 32'h1122_3344, 1'b1, 1'b1);
        idle(1);
        drain();

        // 17 absorbed (16 queued + 1 in flight), last 2 hit a full FIFO
        for (int n = 0; n < 19; n++)
            wr(32'h100 + 32'(4 * n), 32'(n), 1'b0, n < 17);
        idle(1);
        drain();
        check("burst_end_addr", {49'd0, write_addr}, 64'h143);
`ifdef DATA_LOADER_OVERFLOW_FLAG_EN
        check("ovf_set", {63'd0, overflow}, 64'd1);
`endif

        wr(32'h1000_0200, 32'h5555_5555, 1'b0, 1'b0);
        idle(40);
        check("filter_hold", {49'd0, write_addr}, 64'h143);

        for (int n = 0; n < 6; n++)
            wr(32'h300 + 32'(4 * n), 32'hDEAD_BEE0 + 32'(n), 1'b0, 1'b1);
        idle(20);
        @(posedge clk_74a);
        #2;
        reset = 1'b1;
        sb.delete();
        @(negedge clk_74a);
        check("mid_rst_en", {63'd0, write_en}, 64'd0);
        check("mid_rst_addr", {49'd0, write_addr}, 64'd0);
        check("mid_rst_data", {56'd0, write_data}, 64'd0);
`ifdef DATA_LOADER_OVERFLOW_FLAG_EN
        check("mid_rst_ovf", {63'd0, overflow}, 64'd0);
`endif
        repeat (2) @(negedge clk_74a);
        reset = 1'b0;
        last_start = -1000;
        idle(100);
        check("post_rst_en", {63'd0, write_en}, 64'd0);
        check("post_rst_addr", {49'd0, write_addr}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
